// File: rtl/bp_pkg.sv
// Shared definitions for the indexed branch predictor: 2-bit counter
// encoding, PHT reset value, in-flight queue entry layout and the
// saturating counter update helper.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] PHT_RST = WNT;

    // Widest PHT index an entry can carry; the top uses the low bits only.
    localparam int IDX_MAX_W = 8;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic                 pred;
        logic [31:0]          target;
        logic [31:0]          pc4;
    } q_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != ST) res = cnt + 2'd1;
        end else begin
            if (cnt != SNT) res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_inflight_q.sv
// In-order FIFO of predicted-but-unresolved branches. Flush empties it in
// one edge and takes priority over push/pop.
module bp_inflight_q
    import bp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  q_entry_t                   din,
    output q_entry_t                   dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    q_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [CW-1:0]     cnt_q;
    logic              push_ok, pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];

    // Pointer and occupancy tracking; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage; contents are only meaningful where the count says so.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Indexed branch-prediction controller: per-PC 2-bit PHT, in-order tracking
// of outstanding predictions, redirect on mispredict, resolution statistics.
module branch_pred_ctrl
    import bp_pkg::*;
#(
    parameter int PHT_IDX_W = 4,
    parameter int Q_DEPTH   = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             if_branch,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_target,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             pred_take,
    output logic [31:0]      next_pc,
    output logic             redirect,
    output logic             stall_req,
    output logic             res_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int PHT_N = 1 << PHT_IDX_W;

    logic [1:0]                 pht_q [PHT_N];
    logic [PHT_IDX_W-1:0]       if_idx, head_idx;
    logic [31:0]                if_pc4;
    q_entry_t                   enq_entry, head;
    logic [$clog2(Q_DEPTH):0]   q_count;
    logic                       q_full, q_empty;
    logic                       pop, mispredict, push;
    logic                       res_err_q;
    logic [CNT_W-1:0]           branch_cnt_q, mispred_cnt_q;
    logic [IDX_MAX_W-1:0]       unused_head_idx;

    assign if_idx          = if_pc[PHT_IDX_W+1:2];
    assign if_pc4          = if_pc + 32'd4;
    assign head_idx        = head.idx[PHT_IDX_W-1:0];
    assign unused_head_idx = head.idx;

    assign pred_take  = if_branch & pht_q[if_idx][1];
    assign pop        = res_valid & ~stall & ~q_empty;
    assign mispredict = pop & (res_taken != head.pred);
    assign redirect   = mispredict;
    assign stall_req  = if_branch & q_full & ~redirect;
    assign push       = if_branch & ~stall & ~redirect & ~q_full;

    assign enq_entry.idx    = IDX_MAX_W'(if_idx);
    assign enq_entry.pred   = pred_take;
    assign enq_entry.target = if_target;
    assign enq_entry.pc4    = if_pc4;

    bp_inflight_q #(.DEPTH(Q_DEPTH)) u_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (mispredict),
        .din   (enq_entry),
        .dout  (head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Fetch PC selection: recovery first, then hold, then predicted path.
    always_comb begin
        next_pc = if_pc4;
        if (redirect)
            next_pc = head.pred ? head.pc4 : head.target;
        else if (stall || stall_req)
            next_pc = if_pc;
        else if (if_branch && pred_take)
            next_pc = if_target;
    end

    // PHT training on resolution; the IF read this cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= PHT_RST;
        end else if (pop) begin
            pht_q[head_idx] <= sat_update(pht_q[head_idx], res_taken);
        end
    end

    // Saturating statistics and the sticky error for resolutions with nothing in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            res_err_q     <= 1'b0;
        end else begin
            if (pop && branch_cnt_q != '1)         branch_cnt_q  <= branch_cnt_q + 1'b1;
            if (mispredict && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 1'b1;
            if (res_valid && !stall && q_empty)    res_err_q     <= 1'b1;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
    assign res_err     = res_err_q;

    logic unused_count;
    assign unused_count = ^q_count;

endmodule
